// File: rtl/vga_timing_pkg.sv
// 640x480@60 raster constants, bus widths and shared colours for the scan-out
// block and the draw FSMs that fill the frame buffer.
package vga_timing_pkg;

  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_V_TOTAL     = 521;
  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_H_VIS_START = 144;
  localparam int VGA_H_VIS_END   = 783;
  localparam int VGA_V_VIS_START = 35;
  localparam int VGA_V_VIS_END   = 514;
  localparam int VGA_CLK_DIV     = 4;
  localparam int VGA_RD_LATENCY  = 1;

  localparam int PIX_W  = 12;
  localparam int ADDR_W = 19;
  localparam int POS_W  = 16;

  typedef logic [PIX_W-1:0] pixel_t;

  localparam pixel_t COLOR_BLACK = 12'h000;
  localparam pixel_t COLOR_RED   = 12'hF00;
  localparam pixel_t COLOR_GREEN = 12'h0F0;
  localparam pixel_t COLOR_BLUE  = 12'h00F;
  localparam pixel_t COLOR_WHITE = 12'hFFF;

  // Per-pixel attributes carried one tick ahead of the colour data.
  typedef struct packed {
    logic hs;
    logic vs;
    logic vis;
  } scan_flags_t;

  function automatic logic in_range(input logic [POS_W-1:0] p, input int lo, input int hi);
    return (int'(p) >= lo) && (int'(p) <= hi);
  endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Divides the system clock down to the pixel rate: one single-cycle tick
// every CLK_DIV clocks, the first one CLK_DIV clocks after reset release.
module vga_pixel_tick
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = VGA_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_frame_scanout.sv
// VGA scan-out: raster counters, frame-buffer read addressing and a two-stage
// sync/blank pipeline so sync and RGB leave aligned, one pixel tick behind position.
module vga_frame_scanout
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int H_VIS_START = VGA_H_VIS_START,
  parameter int H_VIS_END   = VGA_H_VIS_END,
  parameter int V_VIS_START = VGA_V_VIS_START,
  parameter int V_VIS_END   = VGA_V_VIS_END,
  parameter int CLK_DIV     = VGA_CLK_DIV,
  parameter int RD_LATENCY  = VGA_RD_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [POS_W-1:0]  horizontal_actual_position,
  output logic [POS_W-1:0]  vertical_actual_position,
  output logic              hsync,
  output logic              vsync,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              frame_start
);

  // Read data must settle before the next tick samples it.
  if (RD_LATENCY >= CLK_DIV) begin : g_bad_latency
    $error("vga_frame_scanout: RD_LATENCY (%0d) must be less than CLK_DIV (%0d)",
           RD_LATENCY, CLK_DIV);
  end

  logic tick;

  vga_pixel_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  logic [POS_W-1:0]  h, v;
  logic [POS_W-1:0]  h_next, v_next;
  logic [ADDR_W-1:0] addr_next;
  logic              wrap_next;
  scan_flags_t       flags_next, flags_p1;
  pixel_t            rgb_p2;

  always_comb begin
    h_next = h + 1'b1;
    v_next = v;
    if (h == POS_W'(H_TOTAL - 1)) begin
      h_next = '0;
      v_next = (v == POS_W'(V_TOTAL - 1)) ? '0 : v + 1'b1;
    end
  end

  assign addr_next = ADDR_W'(v_next) * ADDR_W'(H_TOTAL) + ADDR_W'(h_next);
  assign wrap_next = (h_next == '0) && (v_next == '0);

  always_comb begin
    flags_next.hs  = in_range(h_next, 0, H_SYNC - 1);
    flags_next.vs  = in_range(v_next, 0, V_SYNC - 1);
    flags_next.vis = in_range(h_next, H_VIS_START, H_VIS_END) &&
                     in_range(v_next, V_VIS_START, V_VIS_END);
  end

  // Stage 1 resets to the attributes of (0,0), the position reset parks on,
  // so the first hsync/vsync pulses after reset are full width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h           <= '0;
      v           <= '0;
      rd_addr     <= '0;
      flags_p1    <= '{hs: 1'b1, vs: 1'b1, vis: 1'b0};
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      rgb_p2      <= COLOR_BLACK;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && wrap_next;
      if (tick) begin
        h        <= h_next;
        v        <= v_next;
        rd_addr  <= addr_next;
        flags_p1 <= flags_next;
        // stage 2: rd_data now holds the pixel addressed on the previous tick
        hsync    <= ~flags_p1.hs;
        vsync    <= ~flags_p1.vs;
        rgb_p2   <= flags_p1.vis ? rd_data : COLOR_BLACK;
      end
    end
  end

  assign horizontal_actual_position = h;
  assign vertical_actual_position   = v;
  assign vga_r = rgb_p2[11:8];
  assign vga_g = rgb_p2[7:4];
  assign vga_b = rgb_p2[3:0];

endmodule

// File: tb/tb_vga_frame_scanout.sv
// Scoreboard bench: three scan-out instances (full timing, scaled-down raster,
// full raster at one tick per clock) against a tick-count raster model.
module tb_vga_frame_scanout;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic [18:0] addr;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
    logic        fs;
  } bundle_t;

  typedef struct packed {
    logic [31:0] cyc;
    bundle_t     b;
  } exp_t;

  typedef struct {
    int ht, vt, hs, vs, hvs, hve, vvs, vve, cd;
  } geom_t;

  localparam bundle_t RST_B = '{h: 16'd0, v: 16'd0, addr: 19'd0, hs: 1'b1, vs: 1'b1,
                                rgb: 12'h000, fs: 1'b0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  int          mode = 0;
  int unsigned seed = 0;
  bit          done = 1'b0;
  int          total = 0;
  int          pass = 0;
  bundle_t     obs [3];

  always #5 clk = ~clk;

  function automatic logic [11:0] mem_word(input logic [18:0] a, input int md, input int unsigned sd);
    logic [31:0] x;
    if (md == 0) return 12'hFFF;
    x = {13'b0, a} * 32'd40503 + sd;
    return x[11:0] ^ x[23:12];
  endfunction

  // State after n pixel ticks: position is raster index n mod frame, outputs
  // describe raster index n-1 (one tick behind).
  function automatic bundle_t exp_bundle(input geom_t g, input int n, input bit tick_edge,
                                         input int md, input int unsigned sd);
    bundle_t b;
    int f, p, q, hq, vq;
    bit vis;
    b = RST_B;
    if (n == 0) return b;
    f  = g.ht * g.vt;
    p  = n % f;
    q  = (n - 1) % f;
    hq = q % g.ht;
    vq = q / g.ht;
    b.h    = 16'(p % g.ht);
    b.v    = 16'(p / g.ht);
    b.addr = 19'((p / g.ht) * g.ht + (p % g.ht));
    b.hs   = !(hq < g.hs);
    b.vs   = !(vq < g.vs);
    vis    = (hq >= g.hvs) && (hq <= g.hve) && (vq >= g.vvs) && (vq <= g.vve);
    b.rgb  = vis ? mem_word(19'(vq * g.ht + hq), md, sd) : 12'h000;
    b.fs   = tick_edge && (p == 0);
    return b;
  endfunction

  function automatic string fmt(input bundle_t b);
    return $sformatf("h=%0d v=%0d addr=%0d hs=%b vs=%b rgb=%h fs=%b",
                     b.h, b.v, b.addr, b.hs, b.vs, b.rgb, b.fs);
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int HT  = (gi == 1) ? 24 : 800;
    localparam int VT  = (gi == 1) ? 10 : 521;
    localparam int HS  = (gi == 1) ? 3 : 96;
    localparam int VS  = 2;
    localparam int HVS = (gi == 1) ? 5 : 144;
    localparam int HVE = (gi == 1) ? 20 : 783;
    localparam int VVS = (gi == 1) ? 3 : 35;
    localparam int VVE = (gi == 1) ? 8 : 514;
    localparam int CD  = (gi == 0) ? 4 : (gi == 1) ? 3 : 1;
    localparam int LAT = (gi == 0) ? 1 : (gi == 1) ? 2 : 0;

    logic [18:0] rd_addr;
    logic [11:0] rd_data;
    logic [15:0] hpos, vpos;
    logic        hsync, vsync, fs;
    logic [3:0]  r, g, b;

    vga_frame_scanout #(
      .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC(HS), .V_SYNC(VS),
      .H_VIS_START(HVS), .H_VIS_END(HVE), .V_VIS_START(VVS), .V_VIS_END(VVE),
      .CLK_DIV(CD), .RD_LATENCY(LAT)
    ) dut (
      .clk                        (clk),
      .rst_n                      (rst_n),
      .rd_addr                    (rd_addr),
      .rd_data                    (rd_data),
      .horizontal_actual_position (hpos),
      .vertical_actual_position   (vpos),
      .hsync                      (hsync),
      .vsync                      (vsync),
      .vga_r                      (r),
      .vga_g                      (g),
      .vga_b                      (b),
      .frame_start                (fs)
    );

    assign obs[gi] = {hpos, vpos, rd_addr, hsync, vsync, r, g, b, fs};

    // Frame-buffer model: garbage until the address has been stable LAT clocks.
    if (LAT == 0) begin : g_mem_comb
      assign rd_data = mem_word(rd_addr, mode, seed);
    end else begin : g_mem_seq
      logic [18:0] last_a = '0;
      int          age = 1000;
      always @(posedge clk) begin
        if (rd_addr != last_a) age = 1;
        else if (age < 1000) age = age + 1;
        last_a = rd_addr;
        rd_data <= (age >= LAT) ? mem_word(rd_addr, mode, seed) : 12'($urandom);
      end
    end

    geom_t        gm;
    exp_t         q [$];
    int unsigned  k = 0;
    bundle_t      last_exp = RST_B;
    bundle_t      last_obs = RST_B;
    bit           in_rst = 1'b1;
    bit           fin = 1'b0;

    initial gm = '{ht: HT, vt: VT, hs: HS, vs: VS, hvs: HVS, hve: HVE, vvs: VVS, vve: VVE, cd: CD};

    always @(posedge clk) begin : model
      bundle_t cur;
      if (!rst_n) begin
        k = 0;
        last_exp = RST_B;
      end else begin
        k = k + 1;
        cur = exp_bundle(gm, int'(k) / CD, (int'(k) % CD) == 0, mode, seed);
        if (cur !== last_exp) begin
          q.push_back({k, cur});
          last_exp = cur;
        end
      end
    end

    always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst_n) begin
        if (!in_rst) begin
          in_rst = 1'b1;
          total++;
          if (q.size() == 0) pass++;
          else $display("FAIL drain_before_reset inst%0d: %0d updates pending, required 0", gi, q.size());
          q.delete();
        end
        last_obs = RST_B;
      end else begin
        in_rst = 1'b0;
        if (obs[gi] !== last_obs) begin
          last_obs = obs[gi];
          total++;
          if (q.size() == 0) begin
            $display("FAIL unexpected_update inst%0d cyc=%0d: got %s, required no change", gi, k, fmt(obs[gi]));
          end else begin
            e = q.pop_front();
            if (e.cyc == k && e.b === obs[gi]) pass++;
            else $display("FAIL scan_update inst%0d: got cyc=%0d %s, required cyc=%0d %s",
                          gi, k, fmt(obs[gi]), e.cyc, fmt(e.b));
          end
        end
      end
      if (done && !fin) begin
        fin = 1'b1;
        total++;
        if (q.size() == 0) pass++;
        else $display("FAIL final_drain inst%0d: %0d updates pending, required 0", gi, q.size());
      end
    end
  end

  task automatic check_reset(input string tag);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs[i] === RST_B) pass++;
      else $display("FAIL %s inst%0d: got %s, required %s", tag, i, fmt(obs[i]), fmt(RST_B));
    end
  endtask

  // Async reset asserted between clock edges while instance 0 sits at h=400.
  task automatic mid_reset(input string tag);
    int c;
    c = 0;
    while (obs[0].h != 16'd400 && c < 4000) begin
      @(posedge clk);
      c++;
    end
    total++;
    if (obs[0].h == 16'd400) pass++;
    else $display("FAIL %s_wait: got h=%0d after %0d clk, required h=400", tag, obs[0].h, c);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset(tag);
    repeat (10) @(posedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (10) @(posedge clk);
    #1 check_reset("reset_hold");

    // all-white memory: blanking windows and boundaries visible directly in rgb
    mode = 0;
    @(negedge clk) rst_n = 1'b1;
    repeat (29700) @(posedge clk);
    mid_reset("mid_reset_1");

    mode = 1;
    seed = $urandom;
    @(negedge clk) rst_n = 1'b1;
    repeat (7000) @(posedge clk);
    mid_reset("mid_reset_2");

    seed = $urandom;
    @(negedge clk) rst_n = 1'b1;
    repeat (600) @(posedge clk);

    @(negedge clk);
    #1 done = 1'b1;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
